// File: rtl/punch_pkg.sv
// Shared types and constants for the PunchZombi game blocks.
// Holds the round-controller state encoding, LED one-hot codes and LFSR taps.
package punch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [2:0] LED_NONE = 3'b000;
    localparam logic [2:0] LED_1    = 3'b001;
    localparam logic [2:0] LED_2    = 3'b010;
    localparam logic [2:0] LED_3    = 3'b100;

    // x^8 + x^6 + x^5 + x^4 + 1 expressed as a mask over lfsr[7:0]
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [2:0] hole_led(input logic [7:0] rnd);
        logic [7:0] hole;
        hole = rnd % 8'd3;
        case (hole)
            8'd0:    return LED_1;
            8'd1:    return LED_2;
            default: return LED_3;
        endcase
    endfunction

endpackage

// File: rtl/zombie_round_ctrl_if.sv
// Player-facing signal bundle of the round controller: start/buttons in,
// LEDs, score, lives and status pulses out.
interface zombie_round_ctrl_if #(
    parameter int SCORE_W = 8
);
    logic               start;
    logic [3:1]         btn;
    logic [3:1]         led;
    logic [SCORE_W-1:0] score;
    logic [1:0]         lives;
    logic               busy;
    logic               game_over;
    logic               hit_pulse;
    logic               miss_pulse;

    modport master (
        output start, btn,
        input  led, score, lives, busy, game_over, hit_pulse, miss_pulse
    );

    modport slave (
        input  start, btn,
        output led, score, lives, busy, game_over, hit_pulse, miss_pulse
    );
endinterface

// File: rtl/zombie_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick zombie holes.
// Advances every cycle; reloads the seed on reset.
module zombie_lfsr
    import punch_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/zombie_round_ctrl.sv
// Whack-a-zombie round sequencer: dark gap, one lit hole, judge the press,
// then track score and lives until the game ends.
module zombie_round_ctrl
    import punch_pkg::*;
#(
    parameter int         GAP_CYCLES  = 25_000_000,
    parameter int         SHOW_CYCLES = 50_000_000,
    parameter int         LIVES       = 3,
    parameter int         SCORE_W     = 8,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    zombie_round_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (GAP_CYCLES > SHOW_CYCLES) ? GAP_CYCLES : SHOW_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         led_q, led_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic [2:0]         btn_q;
    logic               start_q;
    logic [2:0]         press;
    logic               go;
    logic [7:0]         lfsr;

    zombie_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    always_comb begin
        press   = bus.btn & ~btn_q;
        go      = bus.start & ~start_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        score_d = score_q;
        lives_d = lives_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                led_d = LED_NONE;
                if (go) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    score_d = '0;
                    lives_d = 2'(LIVES);
                end
            end
            GAP: begin
                led_d = LED_NONE;
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    led_d   = hole_led(lfsr);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: begin
                // Wrong or extra buttons outrank a correct one pressed in the same cycle
                if ((press & ~led_q) != 3'b000) begin
                    miss_d = 1'b1;
                end else if ((press != 3'b000) && (press == led_q)) begin
                    hit_d = 1'b1;
                end else if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
                    miss_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (hit_d) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    led_d   = LED_NONE;
                    if (score_q != '1) begin
                        score_d = score_q + 1'b1;
                    end
                end else if (miss_d) begin
                    cnt_d = '0;
                    led_d = LED_NONE;
                    if (lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                    end
                    state_d = (lives_q <= 2'd1) ? OVER : GAP;
                end
            end
            default: begin
                state_d = IDLE;
                led_d   = LED_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            led_q   <= LED_NONE;
            score_q <= '0;
            lives_q <= 2'(LIVES);
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            btn_q   <= 3'b000;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            btn_q   <= bus.btn;
            start_q <= bus.start;
        end
    end

    assign bus.led        = led_q;
    assign bus.score      = score_q;
    assign bus.lives      = lives_q;
    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
    assign bus.busy       = (state_q == GAP) || (state_q == SHOW);
    assign bus.game_over  = (state_q == OVER);

endmodule

// File: doc/zombie_round_ctrl.md
Name: zombie_round_ctrl

Overview:
Game sequencer for the PunchZombi board. It picks a hole pseudo-randomly and lights that LED for a bounded window. It then judges button presses as a hit or a miss, and tracks score and lives until game over. It drives the 3 LEDs directly and replaces the free-running button-to-LED mapping during play.

Parameters:
GAP_CYCLES, 25_000_000, cycles all LEDs stay dark between zombies (>=1)
SHOW_CYCLES, 50_000_000, max cycles a zombie LED stays lit (>=1)
LIVES, 3, misses allowed before game over (1..3)
SCORE_W, 8, score counter width
LFSR_SEED, 8'hA5, nonzero reset value of hole-select LFSR

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset; clk/rst naming as elsewhere in the codebase; polarity and synchronicity fixed
start  input  1  level, already synchronised; rising edge starts a new game
btn  input  3 [3:1]  buttons, already synchronised and debounced, active-high
led  output  3 [3:1]  one-hot zombie LED, or 000
score  output  SCORE_W  hits this game, saturating
lives  output  2  remaining lives
busy  output  1  high in GAP/SHOW
game_over  output  1  high in OVER
hit_pulse  output  1  one-cycle pulse per hit
miss_pulse  output  1  one-cycle pulse per miss (wrong button or timeout)

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, led=000, score=0, lives=LIVES, pulses=0, counters=0, LFSR=LFSR_SEED, btn_q/start_q=0. Reset wins over every other event, including mid-SHOW.
- Edge detect: press[i] = btn[i] & ~btn_q[i]; go = start & ~start_q. btn_q and start_q update every cycle. Held buttons never re-trigger.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle in all states. Hole = (lfsr % 3)+1, sampled on the GAP->SHOW transition.
- States: IDLE, GAP, SHOW, OVER.
- IDLE: outputs quiet. go -> GAP with score=0, lives=LIVES, gap counter=0.
- GAP: led=000. Presses are ignored. Counter reaches GAP_CYCLES-1 -> SHOW. On the same edge: led=onehot(hole), show counter=0.
- SHOW, decision priority per cycle:
  - 1) Any press with a non-target bit set (simultaneous multi-press included) = miss.
  - 2) press == target only = hit.
  - 3) Counter reaches SHOW_CYCLES-1 with no press = timeout miss.
  - 4) Otherwise the counter increments.
- Decision edge: led<=000 and the matching pulse asserts for exactly the next cycle.
  - Hit: score += 1, saturating at all-ones. State -> GAP.
  - Miss: lives -= 1. New lives==0 -> OVER, else -> GAP.
  - Latency from press edge to pulse/led off is 1 cycle. The LED is lit for at most SHOW_CYCLES cycles.
- OVER: led=000, game_over=1. score and lives hold. go -> GAP as a fresh game (score=0, lives=LIVES).
- go in GAP/SHOW is ignored. Only one decision is made per zombie.
- lives never underflows. busy = (state==GAP || state==SHOW).

Decomposition:
- Package punch_pkg: state enum {IDLE,GAP,SHOW,OVER}, LED one-hot constants LED_NONE/LED_1/LED_2/LED_3, LFSR tap mask.
- Sub-module zombie_lfsr (clk, rst, seed param, 8-bit state out) for reuse by later effects blocks.

Test Plan:
- Bench parameters GAP=4, SHOW=8, LIVES=3, seed A5.
- Reset asserted mid-SHOW -> next cycle led=000, score=0, lives=3, state IDLE, no pulse.
- start edge, then at SHOW press only the lit button on show cycle 2 -> next cycle hit_pulse=1 for 1 cycle, led=000, score=1, GAP lasts 4 cycles before the next LED.
- Zombie lit, no press -> LED high exactly 8 cycles, miss_pulse once, lives 3->2.
- Zombie on led[1], press btn=3'b011 simultaneously -> miss, lives decrements, score unchanged.
- Hold btn through GAP into SHOW -> no hit registered (edge only). Timeout miss occurs.
- Three misses -> game_over=1, lives=0, led=000. Further presses have no effect. New start edge -> score=0, lives=3, busy=1.
- Score saturation with SCORE_W=2: 4 hits -> score stays 3, hit_pulse still fires.
